// File: rtl/wb_port_sched_pkg.sv
// Shared constants and source encodings for the
// register-file write-port scheduler.
package wb_port_sched_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int DATA_W     = 32;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/wb_port_sched_if.sv
// Write-back sources, issue-side scoreboard queries
// and register-file write port of the scheduler.
interface wb_port_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_rd;
  logic              rsv_ready;
  logic [ADDR_W-1:0] chk_rs1;
  logic [ADDR_W-1:0] chk_rs2;
  logic              hazard;
  logic              wren;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] reg_data;
  logic              idle;
  logic              err;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output rsv_valid, rsv_rd,
    output chk_rs1, chk_rs2,
    input  a_ready, b_ready, rsv_ready,
    input  hazard, wren, rd_addr,
    input  reg_data, idle, err
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  rsv_valid, rsv_rd,
    input  chk_rs1, chk_rs2,
    output a_ready, b_ready, rsv_ready,
    output hazard, wren, rd_addr,
    output reg_data, idle, err
  );

endinterface

// File: rtl/wb_port_sched_rr_arb2.sv
// Two-way round-robin arbiter; rr_last only moves
// when both sources compete.
module rr_arb2
  import wb_port_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_ready,
  output logic b_ready
);

  src_e rr_last;

  assign a_ready = ~b_valid | (rr_last == SRC_B);
  assign b_ready = ~a_valid | (rr_last == SRC_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= SRC_B;
    end else if (a_valid && b_valid) begin
      rr_last <= a_ready ? SRC_A : SRC_B;
    end
  end

endmodule

// File: rtl/wb_port_sched.sv
// Register-file write-port scheduler: arbitrated
// write-back stage plus busy scoreboard.
module wb_port_sched
  import wb_port_sched_pkg::*;
#(
  parameter int DATA_W = wb_port_sched_pkg::DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NREG   = REG_NUM
) (
  input logic            clk,
  input logic            rst_n,
  wb_port_sched_if.slave bus
);

  localparam int CW = $clog2(NREG + 1);

  logic            acc_a;
  logic            acc_b;
  logic            set;
  logic            clr;
  logic            bad;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   pend_cnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (bus.a_valid),
    .b_valid (bus.b_valid),
    .a_ready (bus.a_ready),
    .b_ready (bus.b_ready)
  );

  assign acc_a = bus.a_valid & bus.a_ready;
  assign acc_b = bus.b_valid & bus.b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wren     <= DISABLE;
      bus.rd_addr  <= '0;
      bus.reg_data <= '0;
    end else begin
      unique case (1'b1)
        acc_a: begin
          bus.wren     <= (bus.a_rd != '0);
          bus.rd_addr  <= bus.a_rd;
          bus.reg_data <= bus.a_data;
        end
        acc_b: begin
          bus.wren     <= (bus.b_rd != '0);
          bus.rd_addr  <= bus.b_rd;
          bus.reg_data <= bus.b_data;
        end
        default: bus.wren <= DISABLE;
      endcase
    end
  end

  // x0 never becomes busy, so reserving it always passes
  assign bus.rsv_ready = ~busy[bus.rsv_rd]
                       | (bus.rsv_rd == '0);

  assign set = bus.rsv_valid & bus.rsv_ready
             & (bus.rsv_rd != '0);
  assign clr = bus.wren & busy[bus.rd_addr];
  assign bad = bus.wren & ~busy[bus.rd_addr];

  always_comb begin
    busy_nxt = busy;
    if (clr) busy_nxt[bus.rd_addr] = 1'b0;
    if (set) busy_nxt[bus.rsv_rd]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
      bus.err  <= DISABLE;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pend_cnt + CW'(set) - CW'(clr);
      if (bad) bus.err <= ENABLE;
    end
  end

  assign bus.hazard =
      (busy[bus.chk_rs1] & (bus.chk_rs1 != '0))
    | (busy[bus.chk_rs2] & (bus.chk_rs2 != '0));

  assign bus.idle = (pend_cnt == '0) & ~bus.wren;

endmodule

// File: tb/tb_wb_port_sched.sv
// Directed vector bench for wb_port_sched.
// One table row per clock cycle plus reset sequences.
module tb_wb_port_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wb_port_sched_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_port_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          av;
    logic [4:0]  ard;
    logic [31:0] ad;
    bit          bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    bit          rv;
    logic [4:0]  rrd;
    logic [4:0]  s1;
    logic [4:0]  s2;
    bit          ar;
    bit          br;
    bit          rr;
    bit          hz;
    bit          wr;
    logic [4:0]  ra;
    logic [31:0] rdat;
    bit          idl;
    bit          er;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(
    bit av, logic [4:0] ard, logic [31:0] ad,
    bit bv, logic [4:0] brd, logic [31:0] bd,
    bit rv, logic [4:0] rrd,
    logic [4:0] s1, logic [4:0] s2,
    bit ar, bit br, bit rr, bit hz, bit wr,
    logic [4:0] ra, logic [31:0] rdat,
    bit idl, bit er);
    vec_t r;
    r.av = av; r.ard = ard; r.ad = ad;
    r.bv = bv; r.brd = brd; r.bd = bd;
    r.rv = rv; r.rrd = rrd; r.s1 = s1; r.s2 = s2;
    r.ar = ar; r.br = br; r.rr = rr; r.hz = hz;
    r.wr = wr; r.ra = ra; r.rdat = rdat;
    r.idl = idl; r.er = er;
    return r;
  endfunction

  task automatic drive_idle();
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    bus.rsv_valid = 0; bus.rsv_rd = 0;
    bus.chk_rs1 = 0; bus.chk_rs2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // av ard ad  bv brd bd  rv rrd s1 s2 | ar br rr hz wr ra rdat idl er
    tbl.push_back(v(0,0,0, 0,0,0, 1,5, 5,0,
                    0,0,1,0,0,0,0, 1,0));
    tbl.push_back(v(1,5,32'hDEAD0001, 0,0,0, 0,0, 5,0,
                    1,0,0,1,0,0,0, 0,0));
    tbl.push_back(v(0,0,0, 0,0,0, 0,0, 5,0,
                    0,0,0,1,1,5,32'hDEAD0001, 0,0));
    tbl.push_back(v(0,0,0, 0,0,0, 0,0, 5,0,
                    0,0,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,0,0, 0,0,0, 1,3, 0,0,
                    0,0,1,0,0,0,0, 1,0));
    tbl.push_back(v(0,0,0, 0,0,0, 1,4, 0,0,
                    0,0,1,0,0,0,0, 0,0));
    tbl.push_back(v(1,3,32'h33, 1,4,32'h44, 0,0, 3,4,
                    1,0,0,1,0,0,0, 0,0));
    tbl.push_back(v(1,3,32'h33, 1,4,32'h44, 0,0, 3,0,
                    0,1,0,1,1,3,32'h33, 0,0));
    tbl.push_back(v(1,3,32'h333, 1,4,32'h444, 1,3, 3,0,
                    1,0,1,0,1,4,32'h44, 0,0));
    tbl.push_back(v(1,3,32'h333, 1,4,32'h444, 1,4, 4,0,
                    0,1,1,0,1,3,32'h333, 0,0));
    tbl.push_back(v(0,0,0, 0,0,0, 0,0, 4,0,
                    0,0,0,1,1,4,32'h444, 0,0));
    tbl.push_back(v(0,0,0, 0,0,0, 0,0, 4,0,
                    0,0,0,0,0,0,0, 1,0));
    tbl.push_back(v(1,0,32'hFFFFFFFF, 0,0,0, 0,0, 0,0,
                    1,0,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,0,0, 0,0,0, 0,0, 0,0,
                    0,0,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,0,0, 0,0,0, 1,7, 7,0,
                    0,0,1,0,0,0,0, 1,0));
    tbl.push_back(v(0,0,0, 0,0,0, 1,7, 7,0,
                    0,0,0,1,0,0,0, 0,0));
    tbl.push_back(v(1,7,32'h77, 0,0,0, 1,7, 7,0,
                    1,0,0,1,0,0,0, 0,0));
    tbl.push_back(v(0,0,0, 0,0,0, 1,8, 7,0,
                    0,0,1,1,1,7,32'h77, 0,0));
    tbl.push_back(v(0,0,0, 0,0,0, 0,0, 7,0,
                    0,0,0,0,0,0,0, 0,0));
    tbl.push_back(v(1,8,32'h88, 0,0,0, 0,0, 8,0,
                    1,0,0,1,0,0,0, 0,0));
    tbl.push_back(v(0,0,0, 0,0,0, 0,0, 8,0,
                    0,0,0,1,1,8,32'h88, 0,0));
    tbl.push_back(v(0,0,0, 0,0,0, 0,0, 8,0,
                    0,0,0,0,0,0,0, 1,0));

    // reset state
    drive_idle();
    bus.rsv_rd = 5; bus.chk_rs1 = 5; bus.chk_rs2 = 31;
    repeat (2) @(posedge clk);
    #1;
    chk("rst wren", 32'(bus.wren), 0);
    chk("rst err", 32'(bus.err), 0);
    chk("rst idle", 32'(bus.idle), 1);
    chk("rst rsv_ready", 32'(bus.rsv_ready), 1);
    chk("rst hazard", 32'(bus.hazard), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post-rst wren", 32'(bus.wren), 0);
    chk("post-rst idle", 32'(bus.idle), 1);

    foreach (tbl[i]) begin
      bus.a_valid = tbl[i].av;
      bus.a_rd = tbl[i].ard;
      bus.a_data = tbl[i].ad;
      bus.b_valid = tbl[i].bv;
      bus.b_rd = tbl[i].brd;
      bus.b_data = tbl[i].bd;
      bus.rsv_valid = tbl[i].rv;
      bus.rsv_rd = tbl[i].rrd;
      bus.chk_rs1 = tbl[i].s1;
      bus.chk_rs2 = tbl[i].s2;
      #1;
      if (tbl[i].av)
        chk($sformatf("v%0d a_ready", i),
            32'(bus.a_ready), 32'(tbl[i].ar));
      if (tbl[i].bv)
        chk($sformatf("v%0d b_ready", i),
            32'(bus.b_ready), 32'(tbl[i].br));
      if (tbl[i].rv)
        chk($sformatf("v%0d rsv_ready", i),
            32'(bus.rsv_ready), 32'(tbl[i].rr));
      chk($sformatf("v%0d hazard", i),
          32'(bus.hazard), 32'(tbl[i].hz));
      chk($sformatf("v%0d wren", i),
          32'(bus.wren), 32'(tbl[i].wr));
      if (tbl[i].wr) begin
        chk($sformatf("v%0d rd_addr", i),
            32'(bus.rd_addr), 32'(tbl[i].ra));
        chk($sformatf("v%0d reg_data", i),
            bus.reg_data, tbl[i].rdat);
      end
      chk($sformatf("v%0d idle", i),
          32'(bus.idle), 32'(tbl[i].idl));
      chk($sformatf("v%0d err", i),
          32'(bus.err), 32'(tbl[i].er));
      step();
    end

    // reset mid-stream with x9 busy and A in flight
    drive_idle();
    bus.rsv_valid = 1; bus.rsv_rd = 9;
    step();
    bus.rsv_valid = 0;
    bus.a_valid = 1; bus.a_rd = 9; bus.a_data = 32'h99;
    bus.chk_rs1 = 9;
    step();
    chk("t6 pre wren", 32'(bus.wren), 1);
    chk("t6 pre hazard", 32'(bus.hazard), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 rst wren", 32'(bus.wren), 0);
    chk("t6 rst rd_addr", 32'(bus.rd_addr), 0);
    chk("t6 rst reg_data", bus.reg_data, 0);
    chk("t6 rst hazard", 32'(bus.hazard), 0);
    chk("t6 rst idle", 32'(bus.idle), 1);
    repeat (2) @(posedge clk);
    bus.a_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6 after wren", 32'(bus.wren), 0);
    step();
    chk("t6 after wren2", 32'(bus.wren), 0);
    chk("t6 after hazard", 32'(bus.hazard), 0);
    chk("t6 after err", 32'(bus.err), 0);

    // B commits x12 with no reservation
    bus.b_valid = 1; bus.b_rd = 12; bus.b_data = 32'h12;
    step();
    bus.b_valid = 0;
    chk("t7 wren", 32'(bus.wren), 1);
    chk("t7 rd_addr", 32'(bus.rd_addr), 12);
    chk("t7 err pre", 32'(bus.err), 0);
    step();
    chk("t7 err set", 32'(bus.err), 1);
    chk("t7 idle", 32'(bus.idle), 1);
    repeat (3) step();
    chk("t7 err sticky", 32'(bus.err), 1);
    rst_n = 1'b0;
    #1;
    chk("t7 err rst", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
